// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash command sequencer.
//   state_e     : sequencer FSM states
//   OP_*        : common flash instruction bytes
//   HDR_W/TOT_W : widths of the header-length and total-length counters
//   calc_hdr    : header length (opcode + optional address + dummy bytes)
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_HDR  = 3'd2,
    ST_DATA = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;

  // Largest header is 1 + 4 + 15 = 20 bytes.
  localparam int HDR_W = 5;
  // Largest transfer is 20 + 65535 bytes; x8 still fits in 24 bits.
  localparam int TOT_W = 17;

  function automatic logic [HDR_W-1:0] calc_hdr(input logic addr_en,
                                                input logic [3:0] dummy,
                                                input int addr_bytes);
    logic [HDR_W-1:0] a;
    a = addr_en ? HDR_W'(addr_bytes) : {HDR_W{1'b0}};
    return 5'd1 + a + {1'b0, dummy};
  endfunction

endpackage

// File: rtl/spi_flash_cmd_seq_rx_filter.sv
// Read-side filter for the SPI flash command sequencer.
// Counts every byte returned by spi_master during a command, drops the
// header-phase bytes and anything beyond the expected total, and forwards
// data-phase bytes of read commands with one cycle of latency.
//   clock, rst_n  : block clock, synchronous active-low reset
//   clr           : restart the byte count (command accepted)
//   en            : a command is in flight
//   rd, hdr, total: latched command shape
//   m_rd_vld/data : spi_master read port
//   rx_full       : all expected bytes have been received
//   rx_vld/data   : forwarded read payload
module spi_flash_rx_filter
  import spi_flash_pkg::*;
(
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             rd,
  input  logic [HDR_W-1:0] hdr,
  input  logic [TOT_W-1:0] total,
  input  logic             m_rd_vld,
  input  logic [7:0]       m_rd_data,
  output logic             rx_full,
  output logic             rx_vld,
  output logic [7:0]       rx_data
);

  logic [TOT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [7:0]       data_q, data_d;

  // Byte counting and header/overflow filtering.
  always_comb begin
    cnt_d  = cnt_q;
    vld_d  = 1'b0;
    data_d = data_q;
    if (clr) begin
      cnt_d = {TOT_W{1'b0}};
    end else if (en && m_rd_vld && (cnt_q != total)) begin
      // Count saturates at total so late bytes are ignored entirely.
      cnt_d = cnt_q + TOT_W'(1);
      if (rd && (cnt_q >= {{(TOT_W-HDR_W){1'b0}}, hdr})) begin
        vld_d  = 1'b1;
        data_d = m_rd_data;
      end else begin
        vld_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Filter state registers.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt_q  <= {TOT_W{1'b0}};
      vld_q  <= 1'b0;
      data_q <= 8'h00;
    end else begin
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign rx_full = (cnt_q == total);
  assign rx_vld  = vld_q;
  assign rx_data = data_q;

endmodule

// File: rtl/spi_flash_cmd_seq.sv
// SPI flash command sequencer: turns one flash command (opcode, optional
// address, dummy bytes, data phase) into a spi_master transfer request,
// streams header bytes then write data / read filler into spi_master, and
// reports completion or timeout.
//   client : cmd_* (command), tx_* (write payload), rx_* (read payload),
//            done/err (completion strobe, err=1 on timeout/protocol error)
//   master : m_request/m_req_len/m_busy/m_finish, write port m_wr_*,
//            read port m_rd_*
module spi_flash_cmd_seq
  import spi_flash_pkg::*;
#(
  parameter int         ADDR_BYTES = 3,
  parameter logic [7:0] FILL       = 8'h00,
  parameter int         TIMEOUT    = 4096
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic        cmd_addr_en,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_dummy,
  input  logic [15:0] cmd_len,
  input  logic        cmd_rd,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_vld,
  output logic        done,
  output logic        err,
  output logic        m_request,
  output logic [23:0] m_req_len,
  input  logic        m_busy,
  input  logic        m_finish,
  output logic        m_wr_en,
  output logic [7:0]  m_wr_data,
  input  logic        m_wr_ready,
  input  logic        m_rd_vld,
  input  logic [7:0]  m_rd_data
);

  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  state_e           state_q, state_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [31:0]      addr_q, addr_d;
  logic             addr_en_q, addr_en_d;
  logic [15:0]      len_q, len_d;
  logic             rd_q, rd_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic [HDR_W-1:0] idx_q, idx_d;
  logic [15:0]      dcnt_q, dcnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fin_q, fin_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept_s;
  logic [HDR_W-1:0] hdr_new_s;
  logic [1:0]       abyte_sel_s;
  logic [7:0]       hdr_byte_s;
  logic             request_s, wr_en_s, tx_ready_s;
  logic [7:0]       wr_data_s;
  logic             rx_full_s;
  logic             tmo_hit_s;

  assign accept_s  = cmd_valid && (state_q == ST_IDLE);
  assign hdr_new_s = calc_hdr(cmd_addr_en, cmd_dummy, ADDR_BYTES);
  assign tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT - 1));
  // Header index 1 carries the most significant used address byte.
  assign abyte_sel_s = 2'(3'(ADDR_BYTES) - idx_q[2:0]);

  // Header byte for the current header index: opcode, address, then filler.
  always_comb begin
    if (idx_q == {HDR_W{1'b0}}) begin
      hdr_byte_s = opcode_q;
    end else if (addr_en_q && (idx_q <= HDR_W'(ADDR_BYTES))) begin
      hdr_byte_s = addr_q[{abyte_sel_s, 3'b000} +: 8];
    end else begin
      hdr_byte_s = FILL;
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    addr_d     = addr_q;
    addr_en_d  = addr_en_q;
    len_d      = len_q;
    rd_d       = rd_q;
    hdr_d      = hdr_q;
    total_d    = total_q;
    idx_d      = idx_q;
    dcnt_d     = dcnt_q;
    tmo_d      = tmo_q;
    fin_d      = fin_q;
    err_d      = 1'b0;
    request_s  = 1'b0;
    wr_en_s    = 1'b0;
    wr_data_s  = 8'h00;
    tx_ready_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          opcode_d  = cmd_opcode;
          addr_d    = cmd_addr;
          addr_en_d = cmd_addr_en;
          len_d     = cmd_len;
          rd_d      = cmd_rd;
          hdr_d     = hdr_new_s;
          total_d   = {{(TOT_W-HDR_W){1'b0}}, hdr_new_s} + {1'b0, cmd_len};
          idx_d     = {HDR_W{1'b0}};
          dcnt_d    = 16'd0;
          tmo_d     = {TMO_W{1'b0}};
          fin_d     = 1'b0;
          state_d   = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        request_s = 1'b1;
        if (m_finish) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (m_busy) begin
          state_d = ST_HDR;
        end else if (tmo_hit_s) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_HDR: begin
        wr_data_s = hdr_byte_s;
        wr_en_s   = m_wr_ready;
        if (m_finish) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (m_wr_ready) begin
          if (idx_q == (hdr_q - HDR_W'(1))) begin
            tmo_d   = {TMO_W{1'b0}};
            state_d = (len_q == 16'd0) ? ST_WAIT : ST_DATA;
          end else begin
            idx_d = idx_q + HDR_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_DATA: begin
        if (rd_q) begin
          wr_data_s = FILL;
          wr_en_s   = m_wr_ready;
        end else begin
          wr_data_s  = tx_data;
          tx_ready_s = m_wr_ready;
          wr_en_s    = tx_valid && m_wr_ready;
        end
        if (m_finish) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (wr_en_s) begin
          if (dcnt_q == (len_q - 16'd1)) begin
            tmo_d   = {TMO_W{1'b0}};
            state_d = ST_WAIT;
          end else begin
            dcnt_d = dcnt_q + 16'd1;
          end
        end else begin
          dcnt_d = dcnt_q;
        end
      end
      ST_WAIT: begin
        // finish may arrive before the last read byte; remember it.
        if ((m_finish || fin_q) && rx_full_s) begin
          state_d = ST_DONE;
        end else if (tmo_hit_s) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          fin_d = fin_q || m_finish;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_DONE);
  end

  // FSM and command registers.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opcode_q  <= 8'h00;
      addr_q    <= 32'h0;
      addr_en_q <= 1'b0;
      len_q     <= 16'd0;
      rd_q      <= 1'b0;
      hdr_q     <= {HDR_W{1'b0}};
      total_q   <= {TOT_W{1'b0}};
      idx_q     <= {HDR_W{1'b0}};
      dcnt_q    <= 16'd0;
      tmo_q     <= {TMO_W{1'b0}};
      fin_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      addr_q    <= addr_d;
      addr_en_q <= addr_en_d;
      len_q     <= len_d;
      rd_q      <= rd_d;
      hdr_q     <= hdr_d;
      total_q   <= total_d;
      idx_q     <= idx_d;
      dcnt_q    <= dcnt_d;
      tmo_q     <= tmo_d;
      fin_q     <= fin_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  spi_flash_rx_filter u_rx (
    .clock     (clock),
    .rst_n     (rst_n),
    .clr       (accept_s),
    .en        (state_q != ST_IDLE),
    .rd        (rd_q),
    .hdr       (hdr_q),
    .total     (total_q),
    .m_rd_vld  (m_rd_vld),
    .m_rd_data (m_rd_data),
    .rx_full   (rx_full_s),
    .rx_vld    (rx_vld),
    .rx_data   (rx_data)
  );

  // Handshakes are gated by rst_n so an abort drops them immediately.
  assign cmd_ready = (state_q == ST_IDLE);
  assign m_request = request_s && rst_n;
  assign m_wr_en   = wr_en_s && rst_n;
  assign tx_ready  = tx_ready_s && rst_n;
  assign m_wr_data = wr_data_s;
  assign m_req_len = (request_s && rst_n) ? {4'b0000, total_q, 3'b000} : 24'd0;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/spi_flash_cmd_seq.md
Name: spi_flash_cmd_seq

Overview:
Command sequencer sitting between a flash-level client and spi_master (SSIZE=1, CSNUM=8). It accepts one flash command at a time (opcode, optional address, dummy bytes, data phase), issues request/req_len to spi_master, and feeds the spi_master write port with the header bytes and then write data or filler. It drains the spi_master read port, discards header-phase bytes, forwards data-phase bytes for read commands, and signals completion or timeout. spi_master wr/rd ports are clocked by this block's clock.

Parameters:
ADDR_BYTES, 3, address bytes sent when cmd_addr_en=1 (3 or 4)
FILL, 8'h00, MOSI byte pushed during the read data phase
TIMEOUT, 4096, max cycles from request to busy, and from last write to finish

Ports:
clock  in  1  block clock; also spi_master wr_clk/rd_clk
rst_n  in  1  synchronous reset, active low
cmd_valid  in  1  command offer
cmd_ready  out  1  high only in IDLE
cmd_opcode  in  8  instruction byte
cmd_addr_en  in  1  send address
cmd_addr  in  32  address, MSB byte first, low ADDR_BYTES bytes used
cmd_dummy  in  4  dummy bytes (FILL) after address
cmd_len  in  16  data-phase bytes, 0 allowed
cmd_rd  in  1  1=read data phase, 0=write data phase
tx_data  in  8  write payload
tx_valid  in  1  payload valid
tx_ready  out  1  payload accepted when tx_valid&tx_ready
rx_data  out  8  read payload
rx_vld  out  1  one-cycle strobe per read byte
done  out  1  one-cycle pulse at command end
err  out  1  valid with done; 1 = timeout
m_request  out  1  to spi_master.request
m_req_len  out  24  to spi_master.req_len, in bits
m_busy  in  1  from spi_master.busy
m_finish  in  1  from spi_master.finish
m_wr_en  out  1  to spi_master.wr_en
m_wr_data  out  8  to spi_master.wr_data
m_wr_ready  in  1  from spi_master.wr_ready
m_rd_vld  in  1  from spi_master.rd_vld
m_rd_data  in  8  from spi_master.rd_data

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1; counters cleared. Reset mid-command aborts immediately with no done pulse; m_request and m_wr_en drop in the same cycle.
- hdr = 1 + (cmd_addr_en ? ADDR_BYTES : 0) + cmd_dummy; total = hdr + cmd_len; m_req_len = total*8, with 24 bits always sufficient. All cmd_* fields are latched on cmd_valid&cmd_ready.
- FSM:
  - IDLE -> REQ on accept.
  - REQ: m_request=1 and m_req_len held until m_busy=1, then both go to 0 and the FSM moves to HDR. If TIMEOUT cycles pass without busy, go to DONE with err=1.
  - HDR: push opcode, then address bytes MSB-first, then cmd_dummy x FILL. Each push is m_wr_en=1 for one cycle only when m_wr_ready=1. After the last header byte, go to DATA, or to WAIT if cmd_len=0.
  - DATA: for a write, m_wr_en = tx_valid & m_wr_ready, tx_ready = m_wr_ready, and m_wr_data = tx_data. For a read, push cmd_len x FILL with tx_ready=0. After cmd_len pushes, go to WAIT.
  - WAIT: remain until m_finish=1 and rx_cnt = total. Timeout counter restarts on entry; expiry gives DONE with err=1.
  - DONE: one cycle with done=1, then IDLE.
- RX path runs independently of the FSM from REQ onward:
  - rx_cnt increments on each m_rd_vld.
  - Bytes with rx_cnt < hdr are dropped.
  - Later bytes: for a read, rx_vld=m_rd_vld and rx_data=m_rd_data, registered with 1-cycle latency. For a write, they are dropped.
- m_rd_vld beyond total bytes is ignored, and no rx_vld is produced.
- m_finish before all pushes complete is a protocol error: go to DONE with err=1.
- m_wr_ready deassertion stalls a push. Stall cycles do not count toward the WAIT timeout.

Decomposition:
- Package spi_flash_pkg holds:
  - the state enum (IDLE, REQ, HDR, DATA, WAIT, DONE);
  - common opcodes (READ 8'h03, PP 8'h02, RDSR 8'h05, WREN 8'h06);
  - the hdr/total width localparams.
- Natural sub-module: spi_flash_rx_filter, containing the rx_cnt, header-drop and forward logic.

Test Plan:
- WREN (8'h06, no addr, len 0) -> m_req_len=8, one wr push of 8'h06, done=1, err=0, no rx_vld.
- READ 8'h03, addr 24'h012345, len 4, slave returns A0..A3 -> pushes 03,01,23,45,00x4, m_req_len=64, rx_vld x4 with A0..A3 and header bytes dropped.
- PP 8'h02, addr 24'h000100, tx 80..83 with tx_valid gaps and m_wr_ready toggling -> exact MOSI order preserved, m_req_len=64, done, no data loss.
- Fast-read: opcode 8'h0B, cmd_dummy=1, ADDR_BYTES=4 -> hdr=6, first 6 rx bytes dropped.
- Slave never asserts busy -> after 4096 cycles done=1, err=1, m_request=0, cmd_ready returns.
- rst_n low during DATA of a 100-byte write -> next cycle all outputs at reset values, no done; next command completes normally.
